// File: rtl/config_loader.sv
// Serial config loader: shifts in an address+data frame and strobes one cell's load for a cycle.
// Optional trailing parity bit is enabled by defining CONFIG_LOADER_PARITY_EN.
module config_loader #(
  parameter int NCELLS = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sen,
  input  logic              bit_en,
  input  logic              sdi,
  input  logic              err_clr,
  output logic [7:0]        dout,
  output logic [NCELLS-1:0] load,
  output logic              busy,
  output logic [2:0]        err,
  output logic [7:0]        frame_cnt
);

`ifdef CONFIG_LOADER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FB    = ADDR_W + 8 + PAR_W;
  localparam int CNT_W = $clog2(FB + 1);
  localparam logic [ADDR_W:0] NC_W = (ADDR_W+1)'(NCELLS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FB-2:0]     shreg;
  logic              armed;
  logic              sample;
  logic              start;
  logic              last_bit;
  logic              short_err;
  logic [FB-1:0]     frame;
  logic [ADDR_W-1:0] f_addr;
  logic [7:0]        f_data;
  logic              addr_bad;
  logic              par_bad;
  logic              frame_ok;

  assign sample    = sen & bit_en;
  // armed stays low after reset until sen is seen low, so a frame cut by reset cannot resume
  assign start     = (state == IDLE) && armed && sample;
  assign last_bit  = (state == SHIFT) && sample && (bit_cnt == CNT_W'(FB - 1));
  assign short_err = (state == SHIFT) && !sen;
  assign frame     = {shreg, sdi};
  assign f_addr    = frame[FB-1 -: ADDR_W];
  assign f_data    = frame[FB-1-ADDR_W -: 8];
  assign addr_bad  = {1'b0, f_addr} >= NC_W;
`ifdef CONFIG_LOADER_PARITY_EN
  assign par_bad   = ^frame;
`else
  assign par_bad   = 1'b0;
`endif
  assign frame_ok  = !addr_bad && !par_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit)  state_nxt = COMMIT;
        else if (!sen) state_nxt = IDLE;
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = sen ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!sen) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed     <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      load      <= '0;
      err       <= '0;
      frame_cnt <= '0;
    end else begin
      armed <= armed | ~sen;

      if (start || ((state == SHIFT) && sample)) begin
        shreg <= {shreg[FB-3:0], sdi};
      end

      if (start) begin
        bit_cnt <= CNT_W'(1);
      end else if (last_bit || short_err) begin
        bit_cnt <= '0;
      end else if ((state == SHIFT) && sample) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // load is registered so it is high exactly for the COMMIT cycle
      if (last_bit && frame_ok) begin
        load      <= NCELLS'(1) << f_addr;
        dout      <= f_data;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        load <= '0;
      end

      // a new error wins over a simultaneous clear
      err <= (err_clr ? 3'b000 : err) |
             {last_bit & par_bad, last_bit & addr_bad, short_err};
    end
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter NCELLS, default 16: number of downstream 8-bit config cells addressed; legal range 2..16.
REQ-002 Parameter ADDR_W, default 4: frame address field width; NCELLS SHALL be at most 2**ADDR_W.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sen  input  1  serial frame enable; high for the whole frame.
REQ-006 bit_en  input  1  bit strobe; sdi is sampled on a clk edge where sen=1 and bit_en=1.
REQ-007 sdi  input  1  serial data, MSB first.
REQ-008 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-009 dout  output  8  data byte driven to every cell's din.
REQ-010 load  output  NCELLS  one-hot, one-cycle load strobe per cell.
REQ-011 busy  output  1  high while in SHIFT or COMMIT.
REQ-012 err  output  3  sticky flags: [0] short frame, [1] address out of range, [2] parity.
REQ-013 frame_cnt  output  8  count of committed frames, wraps 255->0.

Function
REQ-014 Frame SHALL be ADDR_W address bits followed by 8 data bits, MSB first (12 bits at defaults).
REQ-015 FSM states: IDLE, SHIFT, COMMIT, DRAIN; reset state IDLE.
REQ-016 IDLE->SHIFT on the first sampled bit; the bit counter SHALL count sampled bits only.
REQ-017 SHIFT->COMMIT on the clk edge sampling the last frame bit; load[addr] SHALL be high for exactly the next cycle.
REQ-018 dout SHALL change only on entry to COMMIT and SHALL hold the committed byte until the next commit.
REQ-019 COMMIT->DRAIN if sen=1, else ->IDLE; DRAIN->IDLE when sen=0; bits sampled in DRAIN SHALL be ignored.
REQ-020 sen=0 in SHIFT SHALL discard the frame, set err[0], go to IDLE, with no load pulse.
REQ-021 A complete frame with addr>=NCELLS SHALL set err[1]; no load pulse; frame_cnt unchanged; dout unchanged.
REQ-022 frame_cnt SHALL increment once per load pulse only.
REQ-023 If sen falls on the same edge that samples the last bit, the frame SHALL commit normally.
REQ-024 If err_clr and a new error occur on the same edge, the new error flag SHALL be set.
REQ-025 At most one load bit SHALL be high on any cycle.

Reset
REQ-026 rstn low SHALL immediately force IDLE, dout=0, load=0, busy=0, err=0, frame_cnt=0, bit counter=0.
REQ-027 A frame interrupted by reset SHALL be discarded; after release, a new frame requires sen to be sampled low first.

Configuration
REQ-028 Macro CONFIG_LOADER_PARITY_EN defined: frame gains a trailing parity bit; XOR of all frame bits SHALL be 0, else set err[2], no load pulse.
REQ-029 Macro CONFIG_LOADER_PARITY_EN undefined: no parity bit, frame is ADDR_W+8 bits, err[2] SHALL be constant 0.

Verification
REQ-030 Frame addr=3, data=0xA5, bit_en every cycle -> load=0x0008 for one cycle after the 12th bit; dout=0xA5; frame_cnt=1.
REQ-031 sen drops after 7 bits -> no load pulse, err=3'b001, dout unchanged; err_clr -> err=0.
REQ-032 Frame addr=15 with NCELLS=10 -> err[1]=1, no load, frame_cnt unchanged.
REQ-033 16 bits with sen high, bit_en every 3rd cycle -> one commit after the 12th bit; bits 13-16 ignored in DRAIN.
REQ-034 rstn pulsed low mid-frame after 6 bits -> all outputs 0 at once; next full frame addr=1, data=0x3C commits correctly.
REQ-035 Parity build: frame addr=2, data=0xFF with a wrong parity bit -> err[2]=1, no load; with the correct parity bit -> load[2] pulses.
